// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO for one virtual channel.
// The depth does not have to be a power of two. The read port is
// registered and has a valid strobe. The block also provides an
// occupancy count, programmable almost-empty and almost-full flags,
// sticky overrun and underrun errors, and a peak-occupancy watermark.
`timescale 1ns/1ps

module fifo_param #(
    parameter int BW    = 6,  // data width in bits
    parameter int DEPTH = 8,  // number of entries, 2..2**AW
    parameter int AW    = 3   // pointer width; count width is AW+1
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          fifo_wr,
    input  logic [BW-1:0] fifo_data_in,
    input  logic          fifo_rd,
    input  logic [AW:0]   umbral_bajo,
    input  logic [AW:0]   umbral_alto,
    input  logic          err_clr,
    output logic [BW-1:0] fifo_data_out,
    output logic          fifo_valid,
    output logic [AW:0]   fifo_fill,
    output logic [AW:0]   fifo_max_fill,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          fifo_almost_full,
    output logic          fifo_almost_empty,
    output logic          overrun_err,
    output logic          underrun_err,
    output logic          error_output
);

    // Highest legal pointer value. A pointer wraps here, not at 2**AW.
    localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);
    // Occupancy value that means "completely full".
    localparam logic [AW:0]   DEPTH_FILL = (AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [BW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   fill_q;
    logic [AW:0]   max_fill_q;
    logic          overrun_q;
    logic          underrun_q;
    logic [BW-1:0] data_out_q;
    logic          valid_q;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    logic          full;
    logic          empty;
    logic          rd_ok;
    logic          wr_ok;
    logic          overrun_set;
    logic          underrun_set;
    logic [AW-1:0] wr_ptr_inc;
    logic [AW-1:0] rd_ptr_inc;
    logic [AW:0]   fill_d;

    assign full  = (fill_q == DEPTH_FILL);
    assign empty = (fill_q == '0);

    // A read frees a slot in the same cycle. This lets a full FIFO accept
    // a write together with a read. An empty FIFO never passes write data
    // straight through to the read port.
    assign rd_ok = fifo_rd & ~empty;
    assign wr_ok = fifo_wr & (~full | rd_ok);

    assign overrun_set  = fifo_wr & ~wr_ok;
    assign underrun_set = fifo_rd & ~rd_ok;

    // The pointers wrap explicitly at DEPTH-1. This works for any depth,
    // including depths that are not powers of two.
    assign wr_ptr_inc = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
    assign rd_ptr_inc = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;

    // Next occupancy: increases on a write alone, decreases on a read alone.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        fill_d = fill_q;
        case ({wr_ok, rd_ok})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // Write port of the data array. No write happens while reset_L is low.
    always_ff @(posedge clk) begin
        // NOTE: the data array has no reset. An entry is never read before
        // it has been written, and leaving out the reset keeps the array
        // mappable to plain RAM.
        if (reset_L && wr_ok) begin
            mem[wr_ptr_q] <= fifo_data_in;
        end
    end

    // Pointer, occupancy and registered read-port state.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            // NOTE: sequential state is updated with non-blocking
            // assignments only. With a full FIFO doing a read and a write
            // in the same cycle, the read then returns the old entry and
            // the write replaces it.
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            fill_q  <= fill_d;
            valid_q <= rd_ok;
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_inc;
            end
            if (rd_ok) begin
                rd_ptr_q   <= rd_ptr_inc;
                data_out_q <= mem[rd_ptr_q];
            end
        end
    end

    // Sticky error flags. A new error in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            overrun_q  <= (overrun_q  & ~err_clr) | overrun_set;
            underrun_q <= (underrun_q & ~err_clr) | underrun_set;
        end
    end

    // Peak-occupancy watermark. err_clr restarts it from the current fill.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            max_fill_q <= '0;
        end else if (err_clr) begin
            max_fill_q <= fill_q;
        end else if (fill_d > max_fill_q) begin
            max_fill_q <= fill_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Status flags come straight from the fill register and the live
    // threshold inputs, so a threshold change takes effect at once.
    assign fifo_fill         = fill_q;
    assign fifo_max_fill     = max_fill_q;
    assign fifo_full         = full;
    assign fifo_empty        = empty;
    assign fifo_almost_full  = (fill_q >= umbral_alto);
    assign fifo_almost_empty = (fill_q <= umbral_bajo);
    assign fifo_data_out     = data_out_q;
    assign fifo_valid        = valid_q;
    assign overrun_err       = overrun_q;
    assign underrun_err      = underrun_q;
    assign error_output      = overrun_q | underrun_q;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed, table-driven bench for fifo_param. It uses a
// DEPTH=8 instance for the main vectors and a DEPTH=6 instance for the
// pointer-wrap check on a depth that is not a power of two.
`timescale 1ns/1ps

module tb_fifo_param;

    localparam int BW = 6;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic reset_L;

    // DEPTH=8 instance signals
    logic          wr8, rd8, clr8;
    logic [BW-1:0] din8;
    logic [AW:0]   ub, ua;
    logic [BW-1:0] dout8;
    logic          valid8, full8, empty8, af8, ae8, ovr8, unr8, err8;
    logic [AW:0]   fill8, max8;

    // DEPTH=6 instance signals
    logic          wr6, rd6;
    logic [BW-1:0] din6;
    logic [BW-1:0] dout6;
    logic          valid6, full6, empty6, af6, ae6, ovr6, unr6, err6;
    logic [AW:0]   fill6, max6;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_param #(.BW(BW), .DEPTH(8), .AW(AW)) u_dut8 (
        .clk(clk), .reset_L(reset_L),
        .fifo_wr(wr8), .fifo_data_in(din8), .fifo_rd(rd8),
        .umbral_bajo(ub), .umbral_alto(ua), .err_clr(clr8),
        .fifo_data_out(dout8), .fifo_valid(valid8),
        .fifo_fill(fill8), .fifo_max_fill(max8),
        .fifo_full(full8), .fifo_empty(empty8),
        .fifo_almost_full(af8), .fifo_almost_empty(ae8),
        .overrun_err(ovr8), .underrun_err(unr8), .error_output(err8)
    );

    fifo_param #(.BW(BW), .DEPTH(6), .AW(AW)) u_dut6 (
        .clk(clk), .reset_L(reset_L),
        .fifo_wr(wr6), .fifo_data_in(din6), .fifo_rd(rd6),
        .umbral_bajo(ub), .umbral_alto(ua), .err_clr(1'b0),
        .fifo_data_out(dout6), .fifo_valid(valid6),
        .fifo_fill(fill6), .fifo_max_fill(max6),
        .fifo_full(full6), .fifo_empty(empty6),
        .fifo_almost_full(af6), .fifo_almost_empty(ae6),
        .overrun_err(ovr6), .underrun_err(unr6), .error_output(err6)
    );

    typedef struct {
        logic          wr;
        logic          rd;
        logic [BW-1:0] din;
        logic          clr;
        int            e_fill;
        logic          e_valid;
        logic [BW-1:0] e_dout;
        logic          e_ovr;
        logic          e_unr;
        int            e_max;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic rd, input int din,
                                input logic clr, input int fill, input logic valid,
                                input int dout, input logic ovr, input logic unr,
                                input int mx);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = BW'(din); v.clr = clr;
        v.e_fill = fill; v.e_valid = valid; v.e_dout = BW'(dout);
        v.e_ovr = ovr; v.e_unr = unr; v.e_max = mx;
        return v;
    endfunction

    // Status flags of the DEPTH=8 instance for a given expected fill.
    task automatic check_flags8(input string tag, input int fill);
        check({tag, " full"},  int'(full8),  int'(fill == 8));
        check({tag, " empty"}, int'(empty8), int'(fill == 0));
        check({tag, " ae"},    int'(ae8),    int'(fill <= int'(ub)));
        check({tag, " af"},    int'(af8),    int'(fill >= int'(ua)));
    endtask

    task automatic idle_all();
        wr8 = 1'b0; rd8 = 1'b0; clr8 = 1'b0; din8 = '0;
        wr6 = 1'b0; rd6 = 1'b0; din6 = '0;
    endtask

    initial begin
        idle_all();
        ub = 4'd2;
        ua = 4'd0;
        reset_L = 1'b0;
        #1;
        // Reset state. With umbral_alto == 0, almost_full is set even when empty.
        check("rst fill",   int'(fill8),  0);
        check("rst empty",  int'(empty8), 1);
        check("rst full",   int'(full8),  0);
        check("rst ae",     int'(ae8),    1);
        check("rst af@0",   int'(af8),    1);
        check("rst valid",  int'(valid8), 0);
        check("rst dout",   int'(dout8),  0);
        check("rst err",    int'(err8),   0);
        check("rst max",    int'(max8),   0);
        ua = 4'd5;
        #1;
        check("rst af@5",   int'(af8),    0);

        // ---- vector table (DEPTH=8, umbral_bajo=2, umbral_alto=5) ----
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1, 0, k + 1, 0, k + 1, 0, 0, 0, 0, k + 1));
        tbl.push_back(mk(1, 0, 'h3F, 0, 8, 0, 0, 1, 0, 8));  // overrun at full
        tbl.push_back(mk(0, 0, 0,     1, 8, 0, 0, 0, 0, 8));  // clear overrun
        tbl.push_back(mk(1, 1, 'h2A, 0, 8, 1, 1, 0, 0, 8));  // full rd+wr
        for (int k = 2; k <= 8; k++)
            tbl.push_back(mk(0, 1, 0, 0, 9 - k, 1, k, 0, 0, 8));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 'h2A, 0, 0, 8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h2A, 0, 0, 8));   // dout holds
        tbl.push_back(mk(1, 1, 'h15, 0, 1, 0, 'h2A, 0, 1, 8)); // empty rd+wr
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 'h15, 0, 1, 8));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 'h15, 0, 1, 0));   // clr + new err
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 'h15, 0, 0, 0));
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(1, 0, 'h10 + k, 0, k + 1, 0, 'h15, 0, 0, k + 1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 1, 0, 0, 5 - k, 1, 'h10 + k, 0, 0, 6));
        tbl.push_back(mk(0, 0, 0, 1, 3, 0, 'h12, 0, 0, 3));   // watermark reset
        for (int k = 3; k < 6; k++)
            tbl.push_back(mk(0, 1, 0, 0, 5 - k, 1, 'h10 + k, 0, 0, 3));

        // Release reset away from the clock edge. The first edge honours requests.
        @(negedge clk);
        reset_L = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            wr8 = tbl[i].wr; rd8 = tbl[i].rd; din8 = tbl[i].din; clr8 = tbl[i].clr;
            @(posedge clk);
            #1;
            check({tag, " fill"},  int'(fill8),  tbl[i].e_fill);
            check({tag, " valid"}, int'(valid8), int'(tbl[i].e_valid));
            check({tag, " dout"},  int'(dout8),  int'(tbl[i].e_dout));
            check({tag, " ovr"},   int'(ovr8),   int'(tbl[i].e_ovr));
            check({tag, " unr"},   int'(unr8),   int'(tbl[i].e_unr));
            check({tag, " err"},   int'(err8),   int'(tbl[i].e_ovr | tbl[i].e_unr));
            check({tag, " max"},   int'(max8),   tbl[i].e_max);
            check_flags8(tag, tbl[i].e_fill);
        end
        idle_all();

        // A threshold change takes effect without a clock edge.
        ua = 4'd0;
        #1;
        check("thr af live", int'(af8), 1);
        ub = 4'hF;
        ua = 4'd5;
        #1;
        check("thr af back", int'(af8), 0);
        ub = 4'd2;

        // ---- DEPTH=6: fill to full, stream 14 rd+wr, drain; data in order ----
        for (int k = 0; k < 6; k++) begin
            wr6 = 1'b1; din6 = BW'(k);
            @(posedge clk);
            #1;
        end
        check("d6 full",  int'(full6), 1);
        check("d6 fill6", int'(fill6), 6);
        wr6 = 1'b1; din6 = 6'h3F;                     // rejected at full
        @(posedge clk);
        #1;
        check("d6 ovr", int'(ovr6), 1);
        check("d6 fill after ovr", int'(fill6), 6);
        for (int k = 6; k < 20; k++) begin
            wr6 = 1'b1; rd6 = 1'b1; din6 = BW'(k);
            @(posedge clk);
            #1;
            check($sformatf("d6 stream dout%0d", k - 6), int'(dout6), k - 6);
            check($sformatf("d6 stream fill%0d", k - 6), int'(fill6), 6);
        end
        wr6 = 1'b0;
        for (int k = 14; k < 20; k++) begin
            rd6 = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("d6 drain dout%0d", k), int'(dout6), k);
            check($sformatf("d6 drain valid%0d", k), int'(valid6), 1);
        end
        rd6 = 1'b0;
        check("d6 empty", int'(empty6), 1);
        check("d6 max",   int'(max6),   6);

        // ---- Async reset in the middle of a read burst (DEPTH=8) ----
        for (int k = 0; k < 4; k++) begin
            wr8 = 1'b1; din8 = BW'(k + 'h20);
            @(posedge clk);
            #1;
        end
        wr8 = 1'b0; rd8 = 1'b1;
        @(posedge clk);
        #1;
        check("burst dout", int'(dout8), 'h20);
        check("burst valid", int'(valid8), 1);
        #2;
        reset_L = 1'b0;                              // no clock edge here
        #1;
        check("async empty", int'(empty8), 1);
        check("async valid", int'(valid8), 0);
        check("async fill",  int'(fill8),  0);
        check("async dout",  int'(dout8),  0);
        // A write held across an edge while in reset must not be accepted.
        rd8 = 1'b0; wr8 = 1'b1; din8 = 6'h07;
        @(posedge clk);
        #1;
        check("rst no write", int'(fill8), 0);
        @(negedge clk);
        reset_L = 1'b1;
        @(posedge clk);
        #1;
        check("post rst write", int'(fill8), 1);
        wr8 = 1'b0; rd8 = 1'b1;
        @(posedge clk);
        #1;
        check("post rst read", int'(dout8), 'h07);
        idle_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO that generalises the TC/VC queue buffer. It supports arbitrary depth (not necessarily a power of two), a registered read port with a valid strobe, and an occupancy count output. Overrun/underrun errors are sticky and cleared by software, and a peak-occupancy watermark is tracked. The block sits between the traffic-class classifier and the VC arbiter, one instance per virtual channel.

## Interface
- BW, 6, data width in bits
- DEPTH, 8, number of entries (2..2^AW)
- AW, 3, pointer width; count/threshold width is AW+1
- clk  in  1  single clock, all state on rising edge
- reset_L  in  1  asynchronous, active-low reset
- fifo_wr  in  1  write request
- fifo_data_in  in  BW  write data
- fifo_rd  in  1  read request
- umbral_bajo  in  AW+1  almost-empty threshold
- umbral_alto  in  AW+1  almost-full threshold
- err_clr  in  1  clears sticky errors and watermark
- fifo_data_out  out  BW  registered read data
- fifo_valid  out  1  fifo_data_out holds data popped last cycle
- fifo_fill  out  AW+1  current occupancy
- fifo_max_fill  out  AW+1  peak occupancy since reset/err_clr
- fifo_full, fifo_empty  out  1  occupancy == DEPTH / == 0
- fifo_almost_full  out  1  fifo_fill >= umbral_alto
- fifo_almost_empty  out  1  fifo_fill <= umbral_bajo
- overrun_err, underrun_err  out  1  sticky error flags
- error_output  out  1  overrun_err | underrun_err

## Operation
- rd_ok = fifo_rd & !empty.
- wr_ok = fifo_wr & (!full | rd_ok).
- A write with wr_ok stores fifo_data_in at wraddr. Memory is not reset.
- Pointers increment on ok; a pointer at DEPTH-1 wraps to 0. Never use modulo 2^AW when DEPTH is not a power of two.
- Fill update:
  - +1 on wr_ok & !rd_ok
  - -1 on rd_ok & !wr_ok
  - unchanged otherwise
  - Fill never exceeds DEPTH or goes below 0.
- Full with simultaneous rd+wr: both accepted, fill stays DEPTH. The read returns the oldest entry; the new data goes to the freed slot.
- Empty with simultaneous rd+wr: write accepted, read rejected, underrun_err set, fill becomes 1. No fall-through.
- Errors:
  - overrun_err sets on fifo_wr & !wr_ok.
  - underrun_err sets on fifo_rd & !rd_ok.
  - Both hold until err_clr.
  - If err_clr and a new error occur in the same cycle, the flag ends set.
- Watermark: fifo_max_fill is loaded with the next fill value when it exceeds the current maximum. err_clr loads it with the current fill.
- Status flags are combinational from the fill register and the threshold inputs. Thresholds may change at any time and take effect immediately.

## Timing
- Async reset clears pointers, fill, max_fill, error flags, fifo_data_out (0) and fifo_valid (0).
- After reset: fifo_empty=1, fifo_full=0, fifo_almost_empty=1, error_output=0. fifo_almost_full=1 only if umbral_alto==0.
- Reset deassertion is synchronous to clk; the first request is honoured on the first rising edge with reset_L high.
- Reset mid-operation discards all contents immediately. No write occurs in the reset cycle.
- Read latency is 1 cycle:
  - rd_ok at edge N gives fifo_data_out = entry and fifo_valid = 1 after edge N.
  - With no rd_ok, fifo_valid = 0 and fifo_data_out holds its last value.
- Write-to-read latency: data written at edge N is readable with rd_ok at edge N+1 at the earliest (fifo_empty deasserts after edge N).
- fill, flags and errors all update on the same edge as the triggering request. Back-to-back reads/writes run at full rate, one per cycle.

## Test plan
- Reset, then write 0x01..0x08 (DEPTH=8) on 8 cycles -> fill=8, full=1; read 8 -> data 0x01..0x08, valid each cycle after the read, empty=1.
- Full plus one extra write of 0x3F -> overrun_err=1, error_output=1, fill=8, data unchanged; err_clr -> overrun_err=0 the next cycle.
- Empty with rd+wr of 0x15 in the same cycle -> underrun_err=1, fill=1; next read returns 0x15.
- DEPTH=6, AW=3: 20 write/read pairs with data incrementing from 0 -> in-order data, pointers wrap 5->0, fill never above 6.
- umbral_bajo=2, umbral_alto=5; fill walks 0..6..0 -> almost_empty=1 for fill<=2, almost_full=1 for fill>=5; max_fill=6, and err_clr at fill=3 gives max_fill=3.
- Full FIFO with rd+wr of 0x2A -> oldest entry out, fill stays 8, no overrun; assert reset_L low mid-burst -> empty=1 and valid=0 asynchronously.
